im_boot_ctrl: RTL

//  Owns the instruction-memory port. After reset (or on boot_req) it stalls the CPU,

---
 rtl/im_boot_ctrl_if.sv | 25 ++
 rtl/im_boot_ctrl.sv | 113 +++++++++++
 2 files changed

// File: rtl/im_boot_ctrl_if.sv
// rtl/im_boot_ctrl_if.sv - boot controller bus bundle: byte stream, CPU fetch port, IM port, status
interface im_boot_ctrl_if;
    logic [7:0]  rx_byte;
    logic        rx_vld;
    logic        boot_req;
    logic [15:0] cpu_addr;
    logic        cpu_rd_en;
    logic [15:0] im_addr;
    logic        im_rd_en;
    logic        im_we;
    logic [16:0] im_wdata;
    logic        cpu_stall;
    logic        boot_done;
    logic        boot_err;

    modport master (
        output rx_byte, rx_vld, boot_req, cpu_addr, cpu_rd_en,
        input  im_addr, im_rd_en, im_we, im_wdata, cpu_stall, boot_done, boot_err
    );

    modport slave (
        input  rx_byte, rx_vld, boot_req, cpu_addr, cpu_rd_en,
        output im_addr, im_rd_en, im_we, im_wdata, cpu_stall, boot_done, boot_err
    );
endinterface

// File: rtl/im_boot_ctrl.sv
// rtl/im_boot_ctrl.sv - instruction-memory boot loader: byte-stream image to IM, then CPU fetch mux
module im_boot_ctrl #(
    parameter int DEPTH         = 8192,
    parameter bit BOOT_ON_RESET = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    im_boot_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        S_LEN_LO, S_LEN_HI, S_B0, S_B1, S_B2, S_CSUM, S_RUN, S_ERR
    } state_t;

    localparam state_t      RESET_STATE = BOOT_ON_RESET ? S_LEN_LO : S_RUN;
    localparam logic [16:0] DEPTH_W     = 17'(DEPTH);

    state_t      state, state_d;
    logic [15:0] len;
    logic [7:0]  csum;
    logic [15:0] wr_ptr;
    logic [7:0]  b0, b1;
    logic        im_we_q;
    logic [16:0] im_wdata_q;
    logic        boot_done_q;

    logic [15:0] n_hdr;
    logic        word_ok;
    logic        last_word;
    logic        run;

    assign n_hdr     = {bus.rx_byte, len[7:0]};
    assign word_ok   = (bus.rx_byte[7:1] == 7'd0);
    assign last_word = ((wr_ptr + 16'd1) == len);
    assign run       = (state == S_RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RESET_STATE;
        else        state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            S_LEN_LO: if (bus.rx_vld) state_d = S_LEN_HI;
            S_LEN_HI: if (bus.rx_vld)
                state_d = (n_hdr == 16'd0 || {1'b0, n_hdr} > DEPTH_W) ? S_ERR : S_B0;
            S_B0:     if (bus.rx_vld) state_d = S_B1;
            S_B1:     if (bus.rx_vld) state_d = S_B2;
            S_B2:     if (bus.rx_vld) begin
                if (!word_ok)       state_d = S_ERR;
                else if (last_word) state_d = S_CSUM;
                else                state_d = S_B0;
            end
            S_CSUM:   if (bus.rx_vld) state_d = (bus.rx_byte == csum) ? S_RUN : S_ERR;
            S_RUN,
            S_ERR:    if (bus.boot_req) state_d = S_LEN_LO;
            default:  state_d = RESET_STATE;
        endcase
    end

    // wr_ptr advances on the write cycle itself so im_addr shows the word's own address
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len         <= '0;
            csum        <= '0;
            wr_ptr      <= '0;
            b0          <= '0;
            b1          <= '0;
            im_we_q     <= 1'b0;
            im_wdata_q  <= '0;
            boot_done_q <= 1'b0;
        end else begin
            im_we_q     <= 1'b0;
            boot_done_q <= 1'b0;
            if (im_we_q) wr_ptr <= wr_ptr + 16'd1;
            if (bus.rx_vld) begin
                case (state)
                    S_LEN_LO: begin
                        len[7:0] <= bus.rx_byte;
                        csum     <= '0;
                        wr_ptr   <= '0;
                    end
                    S_LEN_HI: len[15:8] <= bus.rx_byte;
                    S_B0: begin
                        b0   <= bus.rx_byte;
                        csum <= csum ^ bus.rx_byte;
                    end
                    S_B1: begin
                        b1   <= bus.rx_byte;
                        csum <= csum ^ bus.rx_byte;
                    end
                    S_B2: if (word_ok) begin
                        csum       <= csum ^ bus.rx_byte;
                        im_wdata_q <= {bus.rx_byte[0], b1, b0};
                        im_we_q    <= 1'b1;
                    end
                    S_CSUM: if (bus.rx_byte == csum) boot_done_q <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

    assign bus.im_addr   = run ? bus.cpu_addr : wr_ptr;
    assign bus.im_rd_en  = run & bus.cpu_rd_en;
    assign bus.im_we     = im_we_q;
    assign bus.im_wdata  = im_wdata_q;
    assign bus.cpu_stall = !run;
    assign bus.boot_done = boot_done_q;
    assign bus.boot_err  = (state == S_ERR);

endmodule
